// File: rtl/fetch_queue.sv
// fetch_queue: IF-stage program counter, instruction-memory address and prefetch FIFO toward ID.
// Optional macro FETCH_BYPASS_EN forwards imem_data straight to decode while the FIFO is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    // DEPTH must be a power of two so the pointers wrap for free.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q    [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic bypass;
    logic pop;
    logic fifo_pop;
    logic fetch;
    logic push;

    assign imem_addr = pc_q;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
`ifdef FETCH_BYPASS_EN
        bypass     = fifo_empty & ~rst & ~redirect;
`else
        bypass     = 1'b0;
`endif
        id_valid   = ~fifo_empty | bypass;
        id_instr   = bypass ? imem_data : instr_mem_q[rd_ptr_q];
        id_pc      = bypass ? pc_q : pc_mem_q[rd_ptr_q];

        pop        = id_valid & id_ready;
        fifo_pop   = pop & ~fifo_empty;
        fetch      = ~redirect & (~fifo_full | pop);
        // A bypassed instruction taken by decode this cycle never occupies a slot.
        push       = fetch & ~(bypass & id_ready);
    end

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            // Any pop this cycle still completes; only younger work is squashed.
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) begin
                pc_d = pc_q + 32'd1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= imem_data;
                pc_mem_q[wr_ptr_q]    <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirect, redirect+pop, async reset.
// Expectations follow FETCH_BYPASS_EN when the macro is defined for the build.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    // Memory model: word k holds 32'h1000_0000 + k.
    assign imem_data = 32'h1000_0000 + imem_addr;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold reset across an edge, then release it mid-cycle; caller is in cycle 0 afterwards.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic stream_check(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            if (j < LAT) begin
                check({tag, "_valid_lo"}, 32'(id_valid), 32'd0);
            end else begin
                check({tag, "_valid"}, 32'(id_valid), 32'd1);
                check({tag, "_pc"}, id_pc, 32'(j - LAT));
                check({tag, "_instr"}, id_instr, 32'h1000_0000 + 32'(j - LAT));
            end
            tick();
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        // 1. Streaming
        id_ready = 1'b1;
        do_reset();
        check("strm_addr0", imem_addr, 32'd0);
        stream_check("strm", 6);

        // 2. Back-pressure
        id_ready = 1'b0;
        do_reset();
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j >= 4) begin
                check("bp_addr_hold", imem_addr, 32'd4);
                check("bp_pc_hold", id_pc, 32'd0);
                check("bp_valid", 32'(id_valid), 32'd1);
            end
        end
        id_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", 32'(id_valid), 32'd1);
            check("bp_drain_pc", id_pc, 32'(k));
            tick();
        end

        // 3. Redirect while partially full
        id_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check("rd_pre_addr", imem_addr, 32'd3);
        check("rd_pre_pc", id_pc, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        #1;
        check("rd_n1_valid", 32'(id_valid), (LAT == 0) ? 32'd1 : 32'd0);
        check("rd_n1_addr", imem_addr, 32'h20);
        if (LAT == 0) check("rd_n1_pc", id_pc, 32'h20);
        tick();
        check("rd_n2_valid", 32'(id_valid), 32'd1);
        check("rd_n2_pc", id_pc, 32'h20);
        check("rd_n2_instr", id_instr, 32'h1000_0020);

        // 4. Full FIFO, pop and redirect together
        id_ready = 1'b0;
        do_reset();
        for (int j = 0; j < 4; j++) tick();
        check("sim_full_addr", imem_addr, 32'd4);
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("sim_head_valid", 32'(id_valid), 32'd1);
        check("sim_head_pc", id_pc, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("sim_n1_valid", 32'(id_valid), (LAT == 0) ? 32'd1 : 32'd0);
        check("sim_n1_addr", imem_addr, 32'h40);
        tick();
        check("sim_n2_valid", 32'(id_valid), 32'd1);
        check("sim_n2_pc", id_pc, 32'h40 + 32'(1 - LAT));
        check("sim_n2_instr", id_instr, 32'h1000_0040 + 32'(1 - LAT));

        // 5. Asynchronous reset mid-stream
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        check("ar_pre_addr", imem_addr, 32'd3);
        check("ar_pre_valid", 32'(id_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(id_valid), 32'd0);
        check("ar_pc", id_pc, 32'd0);
        check("ar_instr", id_instr, 32'd0);
        check("ar_addr", imem_addr, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        stream_check("ar_resume", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
